// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_unit
//  Brief    : Instruction-fetch stage with req/ack imem handshake, prefetch
//             FIFO and wrong-path squashing on MEM-stage redirects.
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_req,
    output logic [31:0]                   imem_addr,
    input  logic                          imem_ack,
    input  logic [31:0]                   imem_rdata,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    input  logic                          id_stall,
    output logic                          if_valid,
    output logic [31:0]                   if_pc_incr,
    output logic [31:0]                   if_instr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT    = 2'd1;
    localparam logic [1:0] c_ST_DISCARD = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        w_pc_nxt;
    logic [31:0]        r_disc_addr;
    logic               r_req;
    logic [31:0]        r_pc_mem  [FIFO_DEPTH];
    logic [31:0]        r_ins_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_after;
    logic [31:0]        w_pc_plus4;
    logic [31:0]        w_redir_pc;
    logic               w_push;
    logic               w_pop;
    logic               w_enter_discard;

    assign w_pc_plus4    = r_fetch_pc + 32'd4;
    assign w_redir_pc    = redirect_pc & ~32'h0000_0003;
    assign if_valid      = (r_count != '0);
    assign w_push        = (r_state == c_ST_WAIT) & imem_ack & ~redirect_valid;
    assign w_pop         = if_valid & ~id_stall & ~redirect_valid;
    assign w_count_after = r_count + {{c_PTR_W{1'b0}}, w_push}
                                   - {{c_PTR_W{1'b0}}, w_pop};

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_fetch_pc;
        w_enter_discard = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // A redirect here waits one cycle so the request carries the new PC.
                if (redirect_valid) begin
                    w_pc_nxt = w_redir_pc;
                end else if (r_count < c_DEPTH) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redir_pc;
                    if (imem_ack) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_state_nxt     = c_ST_DISCARD;
                        w_enter_discard = 1'b1;
                    end
                end else if (imem_ack) begin
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = (w_count_after < c_DEPTH) ? c_ST_WAIT : c_ST_IDLE;
                end
            end
            c_ST_DISCARD: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redir_pc;
                end
                if (imem_ack) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_disc_addr <= '0;
            r_req       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_pc_nxt;
            r_req      <= (w_state_nxt != c_ST_IDLE);
            if (w_enter_discard) begin
                r_disc_addr <= r_fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= w_count_after;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= w_pc_plus4;
            r_ins_mem[r_wr_ptr] <= imem_rdata;
        end
    end

    // The squashed request keeps its original address until its ack arrives.
    assign imem_addr  = (r_state == c_ST_DISCARD) ? r_disc_addr : r_fetch_pc;
    assign imem_req   = r_req;
    assign if_pc_incr = if_valid ? r_pc_mem[r_rd_ptr]  : 32'd0;
    assign if_instr   = if_valid ? r_ins_mem[r_rd_ptr] : 32'd0;
    assign fifo_count = r_count;

endmodule
`default_nettype wire
